// File: rtl/data_bus_bridge.sv
// Bridges the CPU data port (combinational read, single-cycle write) onto a waitrequest/readdatavalid bus,
// stalling the CPU until each access completes. Define WRITE_POSTING_EN to let stores retire without stalling.
module data_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_stall,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  input  logic        bus_readdatavalid,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic [31:0] bus_address_q;
  logic [31:0] bus_writedata_q;
  logic [31:0] cpu_readdata_q;
  logic        bus_read_q;
  logic        bus_write_q;
  logic        bus_error_q;
  logic        timeout;

  // The counter sits one below the limit on the last permitted cycle, so a
  // bus state lasts exactly TIMEOUT_CYCLES cycles before aborting.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout = (cnt_q >= TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= 16'd0;
      bus_address_q   <= 32'd0;
      bus_writedata_q <= 32'd0;
      cpu_readdata_q  <= 32'd0;
      bus_read_q      <= 1'b0;
      bus_write_q     <= 1'b0;
      bus_error_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 16'd0;
          if (cpu_write) begin
            bus_address_q   <= cpu_address;
            bus_writedata_q <= cpu_writedata;
            bus_write_q     <= 1'b1;
            state_q         <= WR_REQ;
          end else if (cpu_read) begin
            bus_address_q <= cpu_address;
            bus_read_q    <= 1'b1;
            state_q       <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (!bus_waitrequest) begin
            bus_read_q <= 1'b0;
            cnt_q      <= 16'd0;
            state_q    <= RD_WAIT;
          end else if (timeout) begin
            bus_read_q     <= 1'b0;
            bus_error_q    <= 1'b1;
            cpu_readdata_q <= 32'hFFFF_FFFF;
            cnt_q          <= 16'd0;
            state_q        <= DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        RD_WAIT: begin
          if (bus_readdatavalid) begin
            cpu_readdata_q <= bus_readdata;
            cnt_q          <= 16'd0;
            state_q        <= DONE;
          end else if (timeout) begin
            bus_error_q    <= 1'b1;
            cpu_readdata_q <= 32'hFFFF_FFFF;
            cnt_q          <= 16'd0;
            state_q        <= DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        WR_REQ: begin
          if (!bus_waitrequest || timeout) begin
            bus_write_q <= 1'b0;
            cnt_q       <= 16'd0;
            if (bus_waitrequest) begin
              bus_error_q <= 1'b1;
            end
`ifdef WRITE_POSTING_EN
            state_q <= IDLE;
`else
            state_q <= DONE;
`endif
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        DONE: begin
          cnt_q   <= 16'd0;
          state_q <= IDLE;
        end
        default: begin
          bus_read_q  <= 1'b0;
          bus_write_q <= 1'b0;
          cnt_q       <= 16'd0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cpu_stall = 1'b0;
    if (!reset) begin
      case (state_q)
`ifdef WRITE_POSTING_EN
        // A posted store lets the CPU run on; anything it issues next waits for the write.
        IDLE:    cpu_stall = cpu_read & ~cpu_write;
        WR_REQ:  cpu_stall = cpu_read | cpu_write;
`else
        IDLE:    cpu_stall = cpu_read | cpu_write;
        WR_REQ:  cpu_stall = 1'b1;
`endif
        RD_REQ:  cpu_stall = 1'b1;
        RD_WAIT: cpu_stall = 1'b1;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  assign cpu_readdata   = cpu_readdata_q;
  assign bus_address    = bus_address_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign bus_writedata  = bus_writedata_q;
  assign bus_byteenable = 4'hF;
  assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge: load, store with waitrequest, read/write collision, timeout, reset mid-access.
module tb_data_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_stall;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  logic        bus_readdatavalid;
  logic        bus_error;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  data_bus_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_address       (cpu_address),
    .cpu_read          (cpu_read),
    .cpu_write         (cpu_write),
    .cpu_writedata     (cpu_writedata),
    .cpu_readdata      (cpu_readdata),
    .cpu_stall         (cpu_stall),
    .bus_address       (bus_address),
    .bus_read          (bus_read),
    .bus_write         (bus_write),
    .bus_writedata     (bus_writedata),
    .bus_byteenable    (bus_byteenable),
    .bus_waitrequest   (bus_waitrequest),
    .bus_readdata      (bus_readdata),
    .bus_readdatavalid (bus_readdatavalid),
    .bus_error         (bus_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one access from the current cycle until the CPU is released (DONE),
  // acting as the bus slave: waitrequest held for wr_wait write cycles, read
  // data returned one cycle after the read is accepted when give_rdv is set.
  task automatic run_access(input int wr_wait, input logic [31:0] rdata, input bit give_rdv,
                            output int stalls, output int wcyc, output bit saw_rd,
                            output logic [31:0] ra, output logic [31:0] wa, output logic [31:0] wd,
                            output bit wr_stable);
    bit pend;
    bit done;
    pend = 0; done = 0; stalls = 0; wcyc = 0; saw_rd = 0; wr_stable = 1;
    ra = 32'd0; wa = 32'd0; wd = 32'd0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        done = 1;
        break;
      end
      stalls++;
      if (bus_read && !saw_rd) ra = bus_address;
      saw_rd |= bus_read;
      if (bus_write) begin
        wcyc++;
        if (wcyc == 1) begin
          wa = bus_address;
          wd = bus_writedata;
        end else if (bus_address !== wa || bus_writedata !== wd || bus_byteenable !== 4'hF) begin
          wr_stable = 0;
        end
      end
      bus_waitrequest = bus_write ? (wcyc <= wr_wait) : 1'b0;
      pend = give_rdv && bus_read && !bus_waitrequest;
      tick();
      bus_readdatavalid = pend;
      bus_readdata      = pend ? rdata : 32'd0;
    end
    check("access_completes", 32'(done), 32'd1);
  endtask

  task automatic retire();
    tick();
    cpu_read          = 1'b0;
    cpu_write         = 1'b0;
    bus_readdatavalid = 1'b0;
    bus_waitrequest   = 1'b0;
  endtask

  int          stalls, wcyc;
  bit          saw_rd, wr_stable;
  logic [31:0] ra, wa, wd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cpu_address = 32'd0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_writedata = 32'd0; bus_waitrequest = 1'b0; bus_readdata = 32'd0; bus_readdatavalid = 1'b0;
    tick();
    cpu_read = 1'b1;
    @(negedge clk);
    check("stall_in_reset", 32'(cpu_stall), 32'd0);
    cpu_read = 1'b0;
    tick();
    reset = 1'b0;

    @(negedge clk);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    check("rst_error", 32'(bus_error), 32'd0);
    check("rst_readdata", cpu_readdata, 32'd0);
    check("rst_address", bus_address, 32'd0);
    check("byteenable", 32'(bus_byteenable), 32'hF);

    // Zero-wait load: 3 stall cycles.
    tick();
    cpu_read = 1'b1; cpu_address = 32'h0000_0100;
    run_access(0, 32'hCAFE_0001, 1'b1, stalls, wcyc, saw_rd, ra, wa, wd, wr_stable);
    check("load_stalls", 32'(stalls), 32'd3);
    check("load_data", cpu_readdata, 32'hCAFE_0001);
    check("load_addr", ra, 32'h0000_0100);
    check("load_no_write", 32'(wcyc), 32'd0);
    retire();

`ifndef WRITE_POSTING_EN
    // Store with 4 waitrequest cycles: 5 write cycles, 6 stall cycles.
    cpu_write = 1'b1; cpu_address = 32'h0000_1004; cpu_writedata = 32'h1234_5678;
    run_access(4, 32'd0, 1'b0, stalls, wcyc, saw_rd, ra, wa, wd, wr_stable);
    check("store_stalls", 32'(stalls), 32'd6);
    check("store_wr_cycles", 32'(wcyc), 32'd5);
    check("store_addr", wa, 32'h0000_1004);
    check("store_data", wd, 32'h1234_5678);
    check("store_stable", 32'(wr_stable), 32'd1);
    check("store_done_strobe", 32'(bus_write), 32'd0);
    retire();

    // Read and write together: only the write goes out.
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 32'h0000_0200; cpu_writedata = 32'hA5A5_0F0F;
    run_access(0, 32'd0, 1'b1, stalls, wcyc, saw_rd, ra, wa, wd, wr_stable);
    check("both_no_read", 32'(saw_rd), 32'd0);
    check("both_wr_cycles", 32'(wcyc), 32'd1);
    check("both_stalls", 32'(stalls), 32'd2);
    check("both_data", wd, 32'hA5A5_0F0F);
    retire();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_read) saw_rd = 1;
      tick();
    end
    check("both_no_late_read", 32'(saw_rd), 32'd0);
`endif

    // Load never answered: IDLE + RD_REQ + 8 RD_WAIT cycles, then abort.
    cpu_read = 1'b1; cpu_address = 32'h0000_0300;
    run_access(0, 32'd0, 1'b0, stalls, wcyc, saw_rd, ra, wa, wd, wr_stable);
    check("to_stalls", 32'(stalls), 32'd10);
    check("to_data", cpu_readdata, 32'hFFFF_FFFF);
    check("to_error", 32'(bus_error), 32'd1);
    retire();
    tick(); tick();
    @(negedge clk);
    check("to_error_sticky", 32'(bus_error), 32'd1);
    check("to_idle_stall", 32'(cpu_stall), 32'd0);

    // Reset while in RD_WAIT, followed by a stray readdatavalid.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_read = 1'b1; cpu_address = 32'h0000_0040;
    tick();
    tick();
    @(negedge clk);
    check("rw_in_wait", {30'd0, cpu_stall, bus_read}, 32'd2);
    reset = 1'b1; cpu_read = 1'b0;
    tick();
    reset = 1'b0;
    bus_readdatavalid = 1'b1; bus_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rw_stall", 32'(cpu_stall), 32'd0);
    check("rw_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    check("rw_error", 32'(bus_error), 32'd0);
    tick();
    bus_readdatavalid = 1'b0; bus_readdata = 32'd0;
    @(negedge clk);
    check("rw_readdata", cpu_readdata, 32'd0);
    tick();

`ifdef WRITE_POSTING_EN
    // Posted store then immediate load with 3 waitrequest cycles.
    cpu_write = 1'b1; cpu_address = 32'h0000_2000; cpu_writedata = 32'h5555_AAAA;
    bus_waitrequest = 1'b1;
    @(negedge clk);
    check("post_store_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_address = 32'h0000_3000;
    run_access(3, 32'h0BAD_F00D, 1'b1, stalls, wcyc, saw_rd, ra, wa, wd, wr_stable);
    check("post_wr_cycles", 32'(wcyc), 32'd4);
    check("post_load_stalls", 32'(stalls), 32'd7);
    check("post_load_data", cpu_readdata, 32'h0BAD_F00D);
    check("post_read_addr", ra, 32'h0000_3000);
    check("post_wr_data", wd, 32'h5555_AAAA);
    retire();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
